// File: rtl/alu_iter_if.sv
// alu_iter_if: operand/result handshake bundle for the iterative EX-stage ALU.
//
// Handshake (applies to both channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds valid and its payload unchanged until that transfer.
//   - Issue channel:  in_valid (master) / in_ready (slave), payload a, b, alu_op, cin.
//   - Result channel: out_valid (slave) / out_ready (master), payload c, cout, div_zero.
//   The result payload stays unchanged while out_valid=1 and out_ready=0.
//   flush (master) aborts whatever the unit holds and discards any same-cycle issue.
//
// Modports:
//   master - the pipeline side that issues operations and consumes results.
//   slave  - the ALU.
interface alu_iter_if #(
    parameter int WIDTH = 64
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             cout;
    logic             div_zero;

    modport master (
        output flush, in_valid, a, b, alu_op, cin, out_ready,
        input  in_ready, out_valid, c, cout, div_zero
    );

    modport slave (
        input  flush, in_valid, a, b, alu_op, cin, out_ready,
        output in_ready, out_valid, c, cout, div_zero
    );
endinterface

// File: rtl/alu_iter.sv
// alu_iter: handshaked EX-stage ALU. add/sub/shift/logic ops produce a
// registered result one cycle after issue; mul (shift-add) and div/rem
// (restoring division) iterate one bit per cycle for WIDTH cycles.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset
//   bus      - alu_iter_if slave modport (issue, result, flush)
//   o_state  - current FSM state (0 IDLE, 1 BUSY, 2 DONE) for debug/checkers
module alu_iter #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    alu_iter_if.slave  bus,
    output logic [1:0] o_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SL  = 4'd2;
    localparam logic [3:0] OP_SR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam logic [3:0] OP_REM = 4'd10;

    state_t           r_state;
    logic [SHW-1:0]   r_cnt;
    logic [3:0]       r_op;
    // Shared iteration datapath:
    //   mul: r_x = partial product, r_y = multiplicand (shifts left), r_z = multiplier (shifts right)
    //   div: r_x = partial remainder, r_y = dividend shifting out / quotient shifting in, r_z = divisor
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic             r_dz;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_c;
    logic             r_cout;
    logic             r_div_zero;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_iter_op;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_sc_c;
    logic             w_sc_cout;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_iter_op  = (bus.alu_op == OP_MUL) || (bus.alu_op == OP_DIV) || (bus.alu_op == OP_REM);
    assign w_shamt    = bus.b[SHW-1:0];

    // Single-cycle results; illegal opcodes fall through to zero.
    always_comb begin
        w_add     = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        w_sub     = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        w_sc_c    = '0;
        w_sc_cout = 1'b0;
        case (bus.alu_op)
            OP_ADD:  {w_sc_cout, w_sc_c} = w_add;
            OP_SUB:  {w_sc_cout, w_sc_c} = w_sub;
            OP_SL:   w_sc_c = bus.a << w_shamt;
            OP_SR:   w_sc_c = bus.a >> w_shamt;
            OP_XOR:  w_sc_c = bus.a ^ bus.b;
            OP_OR:   w_sc_c = bus.a | bus.b;
            OP_AND:  w_sc_c = bus.a & bus.b;
            OP_SRA:  w_sc_c = $signed(bus.a) >>> w_shamt;
            default: ;
        endcase
    end

    // One shift-add step and one restoring-division step per BUSY cycle.
    // The partial remainder is always below the divisor, so bit WIDTH of
    // w_diff is set exactly when the trial subtraction would go negative.
    // A zero divisor never goes negative, giving all-ones quotient and
    // remainder = a without any special casing.
    always_comb begin
        w_mul_acc  = r_z[0] ? (r_x + r_y) : r_x;
        w_shift    = {r_x, r_y[WIDTH-1]};
        w_diff     = w_shift - {1'b0, r_z};
        w_rem_next = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        w_quo_next = {r_y[WIDTH-2:0], ~w_diff[WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_dz        <= 1'b0;
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_cout      <= 1'b0;
            r_div_zero  <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_op  <= bus.alu_op;
            r_cnt <= '0;
            if (w_iter_op) begin
                r_state     <= S_BUSY;
                r_out_valid <= 1'b0;
                r_x         <= '0;
                r_y         <= bus.a;
                r_z         <= bus.b;
                r_dz        <= (bus.b == '0) && (bus.alu_op != OP_MUL);
            end else begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
                r_c         <= w_sc_c;
                r_cout      <= w_sc_cout;
                r_div_zero  <= 1'b0;
            end
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_cnt <= r_cnt + SHW'(1);
                    if (r_op == OP_MUL) begin
                        r_x <= w_mul_acc;
                        r_y <= r_y << 1;
                        r_z <= r_z >> 1;
                    end else begin
                        r_x <= w_rem_next;
                        r_y <= w_quo_next;
                    end
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_cout      <= 1'b0;
                        r_div_zero  <= r_dz;
                        if (r_op == OP_MUL)      r_c <= w_mul_acc;
                        else if (r_op == OP_DIV) r_c <= w_quo_next;
                        else                     r_c <= w_rem_next;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.c         = r_c;
    assign bus.cout      = r_cout;
    assign bus.div_zero  = r_div_zero;
    assign o_state       = r_state;
endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, handshaked successor to the combinational pipeline ALU.
- Single-cycle ops (add/sub/shift/logic) return a registered result after 1 cycle.
- mul/div/rem run iteratively over WIDTH cycles (shift-add / restoring division) instead of one combinational cycle.
- Sits in the EX stage. The pipeline stalls on in_ready/out_valid and can kill an in-flight op with flush.

Parameters:
- WIDTH, 64: operand/result width; must be a power of two, ≥8.
- SHW, $clog2(WIDTH): shift-amount bits taken from b.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  abort current op, discard result.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  unit can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- alu_op  in  4  0 add, 1 sub, 2 sl, 3 sr, 4 xor, 5 or, 6 and, 7 sra, 8 mul, 9 div, 10 rem; 11-15 are illegal.
- cin  in  1  carry-in, used by add only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- c  out  WIDTH  result.
- cout  out  1  carry-out (add/sub), else 0.
- div_zero  out  1  div/rem had b==0, valid with out_valid.

Behaviour:
- **Reset.** On rst, state=IDLE, out_valid=0, c=0, cout=0, div_zero=0, iteration counter=0. in_ready=1 in the first cycle after reset.
- **States.**
  - IDLE: in_ready=1.
  - BUSY: iterating, in_ready=0, out_valid=0.
  - DONE: out_valid=1, c/cout/div_zero held stable until the result is taken.
- **Accept and drain.**
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
  - in_ready = IDLE | (DONE & out_ready), so back-to-back issue is allowed when the result drains in the same cycle.
- **Single-cycle ops (0-7, 11-15).** On accept, the result is registered and the state goes to DONE. out_valid is seen the cycle after accept (latency 1).
  - add: {cout,c} = a + b + cin (WIDTH+1-bit sum).
  - sub: {cout,c} = a + ~b + 1; cout=1 means no borrow. cin is ignored.
  - sl/sr/sra: shift amount = b[SHW-1:0]; upper bits of b are ignored. sra is arithmetic.
  - xor/or/and: bitwise.
  - Illegal op: c=0, cout=0, treated as single-cycle.
- **mul (8).** Unsigned shift-add, low WIDTH bits of the product, cout=0. On accept, state→BUSY with counter=0. One multiplier bit is processed per cycle; after WIDTH cycles in BUSY, state→DONE. out_valid is seen WIDTH+1 cycles after the accept edge.
- **div/rem (9/10).** Unsigned restoring division, one quotient bit per cycle. Latency is identical to mul.
  - b==0: c = all-ones (div) or a (rem), div_zero=1. Latency is still WIDTH+1; no early exit.
- **Drain from DONE.** Drain with no new accept → IDLE. Drain together with an accept → the new op starts, so the next state is DONE (single-cycle op) or BUSY (mul/div/rem).
- **flush.** Highest priority after rst. Next state=IDLE, out_valid=0, any accept in the same cycle is discarded. c/cout are don't-care afterwards.
- **Operand capture.** a, b, alu_op and cin are captured on accept. Input changes during BUSY have no effect.
- **Output stability.** While out_valid=1 and out_ready=0, c, cout and div_zero must not change.

Test Plan:
- WIDTH=64, add a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → 1 cycle later out_valid=1, c=0, cout=1.
- sub a=5, b=7 → c=0xFFFF_FFFF_FFFF_FFFE, cout=0.
- sra a=0x8000_0000_0000_0000, b=0x43 → c=0xF000_0000_0000_0000 (shift=3).
- mul a=0x1_0000_0001, b=0xFFFF_FFFF → out_valid exactly 65 cycles after accept, c=0xFFFF_FFFF_FFFF_FFFF. in_ready=0 throughout BUSY.
- div a=100, b=7 → c=14. rem → c=2. div with b=0, a=9 → c=all-ones, div_zero=1. rem with b=0 → c=9.
- Back-pressure and abort:
  - Hold out_ready=0 for 5 cycles after an xor result: c stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (or op) in the same cycle: new result appears the next cycle.
  - flush at cycle 30 of a div → IDLE next cycle, no out_valid for that op.
  - Assert rst mid-mul → all outputs 0 next cycle.
